// File: rtl/calc_pkg.sv
// Shared types and helpers for the TRISC calculator control sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOperand,
    StExec,
    StShow,
    StChain
  } state_e;

  localparam logic ActiveLo   = 1'b0;
  localparam logic InactiveLo = 1'b1;

  // Width of an operand index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronises an active-low raw push-button and emits one registered pulse per debounced press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync2_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CntLast) begin
        press_d = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchroniser clears to "pressed" and the arm flag to 0, so a button held through
  // reset must be seen released before it can fire.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Control sequencer: operand entry, execute, result display, with undo and chained results.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned N_OPERANDS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CHAIN_EN        = 1
) (
  input  logic                                CLK,
  input  logic                                CLR,
  input  logic                                Enter,
  input  logic                                Undo,
  input  logic                                Chain,
  output logic [N_OPERANDS-1:0]               OP_Load,
  output logic                                R_Load,
  output logic                                OU_Load,
  output logic                                RESET,
  output logic                                IU_AU,
  output logic                                FB_Sel,
  output logic [idx_width(N_OPERANDS)-1:0]    Step,
  output logic                                Done
);

  localparam int unsigned     IdxW    = idx_width(N_OPERANDS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_OPERANDS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q;
  logic            enter_ev, undo_ev;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_cond (
    .CLK   (CLK),
    .CLR   (CLR),
    .btn_n (Enter),
    .press (enter_ev)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo_cond (
    .CLK   (CLK),
    .CLR   (CLR),
    .btn_n (Undo),
    .press (undo_ev)
  );

  // Undo always wins over a coincident Enter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (enter_ev && !undo_ev) begin
          state_d = StOperand;
          idx_d   = '0;
        end
      end
      StOperand: begin
        if (undo_ev) begin
          if (idx_q == '0) state_d = StIdle;
          else             idx_d   = idx_q - IdxW'(1);
        end else if (enter_ev) begin
          if (idx_q == IdxLast) begin
            state_d = StExec;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StExec: state_d = StShow;
      StShow: begin
        if (undo_ev) begin
          state_d = StIdle;
        end else if (enter_ev) begin
          idx_d   = '0;
          state_d = (Chain && (CHAIN_EN != 0)) ? StChain : StOperand;
        end
      end
      StChain: begin
        state_d = StOperand;
        idx_d   = IdxW'(1);
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    OP_Load = {N_OPERANDS{InactiveLo}};
    R_Load  = InactiveLo;
    OU_Load = 1'b0;
    RESET   = InactiveLo;
    IU_AU   = 1'b0;
    FB_Sel  = 1'b0;
    Step    = '0;
    case (state_q)
      StIdle: begin
        RESET   = ActiveLo;
        OU_Load = 1'b1;
      end
      StOperand: begin
        Step = idx_q;
        for (int unsigned i = 0; i < N_OPERANDS; i++) begin
          if (idx_q == IdxW'(i)) OP_Load[i] = ActiveLo;
        end
      end
      StExec: begin
        R_Load = ActiveLo;
        IU_AU  = 1'b1;
      end
      StShow: IU_AU = 1'b1;
      StChain: begin
        OP_Load[0] = ActiveLo;
        FB_Sel     = 1'b1;
        IU_AU      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= (state_d == StShow) && (state_q != StShow);
    end
  end

  assign Done = done_q;

endmodule
